mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  MEM-stage load/store unit: consumer of the EX/MEM pipeline register. Issues one
//  data-memory access per load/store over a req/gnt/rvalid bus, stalls the upstream
//  pipeline until the access completes, then loads the MEM/WB pipeline register.
//  Sits between EX/MEM outputs and the WB stage; data memory is external.
// PARAMETERS
//  TIMEOUT_CYCLES  255  cycles an access may stay outstanding before abort (MEM_TIMEOUT_EN only)
//  TO_CNT_W        8    width of timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//  clk                   in   1   clock, rising edge
//  reset                 in   1   asynchronous, active-low reset
//  EX_MEM_RegWrite       in   1   write-back enable of instruction in MEM
//  EX_MEM_MemtoReg       in   2   write-back source select, passed through
//  EX_MEM_MemRead        in   1   load
//  EX_MEM_MemWrite       in   1   store
//  EX_MEM_PCplus4        in   32  PC+4, passed through
//  EX_MEM_RegReadData2   in   32  store data
//  EX_MEM_ALUout         in   32  effective address / ALU result
//  EX_MEM_RegWriteAddr   in   5   destination register
//  dmem_req              out  1   access request
//  dmem_we               out  1   1=store, 0=load; valid with dmem_req
//  dmem_addr             out  32  word address {ALUout[31:2],2'b00}
//  dmem_wdata            out  32  store data
//  dmem_gnt              in   1   request accepted this cycle
//  dmem_rvalid           in   1   load data valid (never earlier than cycle after gnt)
//  dmem_rdata            in   32  load data
//  mem_stall             out  1   1 = upstream must hold EX/MEM and earlier stages
//  mem_err               out  1   1-cycle pulse: misaligned access or timeout
//  MEM_WB_RegWrite       out  1   registered
//  MEM_WB_MemtoReg       out  2   registered
//  MEM_WB_MemReadData    out  32  registered load data; 0 for non-loads
//  MEM_WB_ALUout         out  32  registered
//  MEM_WB_PCplus4        out  32  registered
//  MEM_WB_RegWriteAddr   out  5   registered
// BEHAVIOUR
//  - Reset (reset=0): state IDLE, all MEM_WB_* = 0, mem_err=0, counter=0; dmem_req,
//    mem_stall forced 0 combinationally while reset low. Reset mid-access abandons it.
//  - op = MemRead|MemWrite; both set: treated as store. misaligned = op & ALUout[1:0]!=0.
//  - FSM IDLE: op & !misaligned -> dmem_req=1, dmem_we=MemWrite (comb). On gnt: store
//    completes this cycle; load -> WAIT_RD. No gnt: stay IDLE, req held, stall.
//  - FSM WAIT_RD: dmem_req=0; on rvalid load completes, -> IDLE. rvalid in IDLE ignored.
//  - done = (IDLE & store & gnt) | (WAIT_RD & rvalid) | misaligned | abort.
//  - mem_stall = op & !done (combinational). Non-memory op: never stalls.
//  - MEM_WB update each rising edge: if !op or done -> capture EX_MEM_* fields
//    (MemReadData = rdata on load completion else 0); else bubble (RegWrite=0, rest 0).
//  - Latency: store with gnt in cycle 0 -> MEM_WB valid after edge 0; load gnt cycle 0,
//    rvalid cycle 1 -> MEM_WB valid after edge 1 (2-cycle min load).
//  - Misaligned: no request, no stall, MEM_WB gets bubble (RegWrite=0), mem_err pulse.
//  - Upstream holds EX_MEM_* stable while mem_stall=1; inputs sampled only when needed.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined: counter increments each cycle op outstanding (IDLE w/o gnt
//   or WAIT_RD w/o rvalid), clears on done; at count==TIMEOUT_CYCLES -> abort: drop
//   req, bubble into MEM_WB, mem_err pulse, -> IDLE, stall released same cycle. Late
//   rvalid after abort ignored.
//  MEM_TIMEOUT_EN undefined: no counter; waits indefinitely; mem_err only on misalign.
// TESTING
//  - ALU op (op=0), RegWriteAddr=5, ALUout=0x1234 -> no req, no stall; MEM_WB_ALUout=0x1234 next edge.
//  - Store addr 0x100, data 0xDEADBEEF, gnt after 3 cycles -> req/we=1 4 cycles, stall 3, MEM_WB RegWrite=0.
//  - Load addr 0x40, gnt cycle 0, rvalid cycle 2 rdata=0xCAFEF00D -> stall 2 cycles, MemReadData=0xCAFEF00D.
//  - Load addr 0x41 -> no req, no stall, mem_err 1 cycle, MEM_WB_RegWrite=0.
//  - Load outstanding, reset=0 in WAIT_RD -> req/stall 0 immediately, all MEM_WB_*=0, state IDLE.
//  - MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, gnt never -> abort at 4th cycle, mem_err pulse, stall drops.

Source files
------------

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/grant/read-valid bus between the MEM-stage LSU (master) and data memory (slave).
interface mem_stage_lsu_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one data access per load/store, upstream stall, MEM/WB register.
// Optional access timeout/abort is built when MEM_TIMEOUT_EN is defined.
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  EX_MEM_RegWrite,
    input  logic [1:0]            EX_MEM_MemtoReg,
    input  logic                  EX_MEM_MemRead,
    input  logic                  EX_MEM_MemWrite,
    input  logic [31:0]           EX_MEM_PCplus4,
    input  logic [31:0]           EX_MEM_RegReadData2,
    input  logic [31:0]           EX_MEM_ALUout,
    input  logic [4:0]            EX_MEM_RegWriteAddr,
    mem_stage_lsu_if.master       dmem,
    output logic                  mem_stall,
    output logic                  mem_err,
    output logic                  MEM_WB_RegWrite,
    output logic [1:0]            MEM_WB_MemtoReg,
    output logic [31:0]           MEM_WB_MemReadData,
    output logic [31:0]           MEM_WB_ALUout,
    output logic [31:0]           MEM_WB_PCplus4,
    output logic [4:0]            MEM_WB_RegWriteAddr
);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_WAIT_RD = 1'b1
    } state_t;

    state_t r_state;

    logic w_op;
    logic w_store;
    logic w_misaligned;
    logic w_issue;
    logic w_store_done;
    logic w_load_done;
    logic w_abort;
    logic w_done;
    logic w_capture;

    // A load+store combination is handled as a store.
    assign w_op         = EX_MEM_MemRead | EX_MEM_MemWrite;
    assign w_store      = EX_MEM_MemWrite;
    assign w_misaligned = w_op & (EX_MEM_ALUout[1:0] != 2'b00);
    assign w_issue      = (r_state == S_IDLE) & w_op & ~w_misaligned;
    assign w_store_done = w_issue & w_store & dmem.dmem_gnt;
    assign w_load_done  = (r_state == S_WAIT_RD) & dmem.dmem_rvalid;
    assign w_done       = w_store_done | w_load_done | w_misaligned | w_abort;
    assign w_capture    = ~w_op | w_store_done | w_load_done;

    assign dmem.dmem_req   = reset & w_issue & ~w_abort;
    assign dmem.dmem_we    = EX_MEM_MemWrite;
    assign dmem.dmem_addr  = {EX_MEM_ALUout[31:2], 2'b00};
    assign dmem.dmem_wdata = EX_MEM_RegReadData2;
    assign mem_stall       = reset & w_op & ~w_done;

`ifdef MEM_TIMEOUT_EN
    logic [TO_CNT_W-1:0] r_to_cnt;
    logic                w_outstanding;

    // Abort fires in the TIMEOUT_CYCLES-th outstanding cycle, so the counter value excludes the current cycle.
    assign w_outstanding = (w_issue & ~dmem.dmem_gnt) |
                           ((r_state == S_WAIT_RD) & ~dmem.dmem_rvalid);
    assign w_abort       = w_outstanding & (r_to_cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_to_cnt <= '0;
        end else if (w_done | ~w_op) begin
            r_to_cnt <= '0;
        end else if (w_outstanding) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    assign w_abort = 1'b0;
`endif

    // Access FSM, error pulse and MEM/WB pipeline register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state             <= S_IDLE;
            mem_err             <= 1'b0;
            MEM_WB_RegWrite     <= 1'b0;
            MEM_WB_MemtoReg     <= 2'b00;
            MEM_WB_MemReadData  <= '0;
            MEM_WB_ALUout       <= '0;
            MEM_WB_PCplus4      <= '0;
            MEM_WB_RegWriteAddr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue & dmem.dmem_gnt & ~w_store) begin
                        r_state <= S_WAIT_RD;
                    end
                end
                S_WAIT_RD: begin
                    if (dmem.dmem_rvalid | w_abort) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            mem_err <= w_misaligned | w_abort;

            if (w_capture) begin
                MEM_WB_RegWrite     <= EX_MEM_RegWrite;
                MEM_WB_MemtoReg     <= EX_MEM_MemtoReg;
                MEM_WB_MemReadData  <= w_load_done ? dmem.dmem_rdata : 32'h0;
                MEM_WB_ALUout       <= EX_MEM_ALUout;
                MEM_WB_PCplus4      <= EX_MEM_PCplus4;
                MEM_WB_RegWriteAddr <= EX_MEM_RegWriteAddr;
            end else begin
                MEM_WB_RegWrite     <= 1'b0;
                MEM_WB_MemtoReg     <= 2'b00;
                MEM_WB_MemReadData  <= '0;
                MEM_WB_ALUout       <= '0;
                MEM_WB_PCplus4      <= '0;
                MEM_WB_RegWriteAddr <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized self-checking bench for mem_stage_lsu; expected behaviour is derived per transaction
// from its grant/read-valid delays. Define MEM_TIMEOUT_EN to also exercise the abort path.
module tb_mem_stage_lsu;

    logic        clk;
    logic        reset;
    logic        EX_MEM_RegWrite;
    logic [1:0]  EX_MEM_MemtoReg;
    logic        EX_MEM_MemRead;
    logic        EX_MEM_MemWrite;
    logic [31:0] EX_MEM_PCplus4;
    logic [31:0] EX_MEM_RegReadData2;
    logic [31:0] EX_MEM_ALUout;
    logic [4:0]  EX_MEM_RegWriteAddr;
    logic        mem_stall;
    logic        mem_err;
    logic        MEM_WB_RegWrite;
    logic [1:0]  MEM_WB_MemtoReg;
    logic [31:0] MEM_WB_MemReadData;
    logic [31:0] MEM_WB_ALUout;
    logic [31:0] MEM_WB_PCplus4;
    logic [4:0]  MEM_WB_RegWriteAddr;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage_lsu_if bus ();

    mem_stage_lsu #(.TIMEOUT_CYCLES(4), .TO_CNT_W(8)) dut (
        .clk                 (clk),
        .reset               (reset),
        .EX_MEM_RegWrite     (EX_MEM_RegWrite),
        .EX_MEM_MemtoReg     (EX_MEM_MemtoReg),
        .EX_MEM_MemRead      (EX_MEM_MemRead),
        .EX_MEM_MemWrite     (EX_MEM_MemWrite),
        .EX_MEM_PCplus4      (EX_MEM_PCplus4),
        .EX_MEM_RegReadData2 (EX_MEM_RegReadData2),
        .EX_MEM_ALUout       (EX_MEM_ALUout),
        .EX_MEM_RegWriteAddr (EX_MEM_RegWriteAddr),
        .dmem                (bus),
        .mem_stall           (mem_stall),
        .mem_err             (mem_err),
        .MEM_WB_RegWrite     (MEM_WB_RegWrite),
        .MEM_WB_MemtoReg     (MEM_WB_MemtoReg),
        .MEM_WB_MemReadData  (MEM_WB_MemReadData),
        .MEM_WB_ALUout       (MEM_WB_ALUout),
        .MEM_WB_PCplus4      (MEM_WB_PCplus4),
        .MEM_WB_RegWriteAddr (MEM_WB_RegWriteAddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_mem_wb_zero(input string tag);
        check({tag, "_wb_rw"},   32'(MEM_WB_RegWrite),     32'h0);
        check({tag, "_wb_mtr"},  32'(MEM_WB_MemtoReg),     32'h0);
        check({tag, "_wb_rd"},   MEM_WB_MemReadData,       32'h0);
        check({tag, "_wb_alu"},  MEM_WB_ALUout,            32'h0);
        check({tag, "_wb_pc"},   MEM_WB_PCplus4,           32'h0);
        check({tag, "_wb_wa"},   32'(MEM_WB_RegWriteAddr), 32'h0);
    endtask

    // One EX/MEM instruction held until completion; called and returns at a falling edge.
    // g = cycle (from 0) in which gnt is given; r = cycles from gnt to rvalid for loads.
    task automatic run_txn(input string tag, input logic rd, input logic wr, input int g, input int r,
                           input logic [31:0] alu, input logic [31:0] sdata, input logic [31:0] rdat,
                           input logic rw, input logic [1:0] mtr, input logic [4:0] wa,
                           input logic [31:0] pc);
        logic mis, is_load, is_store, exp_req;
        int   n;
        mis      = (rd | wr) && (alu[1:0] != 2'b00);
        is_store = wr && !mis;
        is_load  = rd && !wr && !mis;
        n        = is_store ? g + 1 : (is_load ? g + r + 1 : 1);

        EX_MEM_RegWrite     = rw;
        EX_MEM_MemtoReg     = mtr;
        EX_MEM_MemRead      = rd;
        EX_MEM_MemWrite     = wr;
        EX_MEM_PCplus4      = pc;
        EX_MEM_RegReadData2 = sdata;
        EX_MEM_ALUout       = alu;
        EX_MEM_RegWriteAddr = wa;

        for (int c = 0; c < n; c++) begin
            bus.dmem_gnt    = (is_load || is_store) && (c == g);
            bus.dmem_rvalid = is_load ? (c == g + r) : 1'($urandom_range(0, 1));
            bus.dmem_rdata  = (is_load && c == g + r) ? rdat : $urandom;
            #1;
            exp_req = (is_load || is_store) && (c <= g);
            check({tag, "_req"},   32'(bus.dmem_req), 32'(exp_req));
            check({tag, "_stall"}, 32'(mem_stall),    32'((is_load || is_store) && (c < n - 1)));
            if (exp_req) begin
                check({tag, "_we"},    32'(bus.dmem_we), 32'(wr));
                check({tag, "_addr"},  bus.dmem_addr,    {alu[31:2], 2'b00});
                if (wr) check({tag, "_wdata"}, bus.dmem_wdata, sdata);
            end
            @(posedge clk);
            #1;
            check({tag, "_err"}, 32'(mem_err), 32'(mis));
            if (c == n - 1) begin
                if (mis) begin
                    check_mem_wb_zero(tag);
                end else begin
                    check({tag, "_wb_rw"},  32'(MEM_WB_RegWrite),     32'(rw));
                    check({tag, "_wb_mtr"}, 32'(MEM_WB_MemtoReg),     32'(mtr));
                    check({tag, "_wb_rd"},  MEM_WB_MemReadData,       is_load ? rdat : 32'h0);
                    check({tag, "_wb_alu"}, MEM_WB_ALUout,            alu);
                    check({tag, "_wb_pc"},  MEM_WB_PCplus4,           pc);
                    check({tag, "_wb_wa"},  32'(MEM_WB_RegWriteAddr), 32'(wa));
                end
            end else begin
                check({tag, "_bubble"}, 32'(MEM_WB_RegWrite), 32'h0);
            end
            @(negedge clk);
        end
        bus.dmem_gnt    = 1'b0;
        bus.dmem_rvalid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        rd, wr, rw;
        logic [31:0] alu;
        int          kind;

        reset               = 1'b1;
        EX_MEM_RegWrite     = 1'b0;
        EX_MEM_MemtoReg     = 2'b00;
        EX_MEM_MemRead      = 1'b0;
        EX_MEM_MemWrite     = 1'b0;
        EX_MEM_PCplus4      = 32'h0;
        EX_MEM_RegReadData2 = 32'h0;
        EX_MEM_ALUout       = 32'h0;
        EX_MEM_RegWriteAddr = 5'd0;
        bus.dmem_gnt        = 1'b0;
        bus.dmem_rvalid     = 1'b0;
        bus.dmem_rdata      = 32'h0;

        // Reset held low with a load presented: no request, no stall, zeroed MEM/WB.
        #1 reset = 1'b0;
        EX_MEM_MemRead = 1'b1;
        EX_MEM_ALUout  = 32'h40;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",   32'(bus.dmem_req), 32'h0);
        check("rst_stall", 32'(mem_stall),    32'h0);
        check("rst_err",   32'(mem_err),      32'h0);
        check_mem_wb_zero("rst");
        @(negedge clk);
        reset = 1'b1;

        run_txn("alu",   1'b0, 1'b0, 0, 0, 32'h0000_1234, 32'h0, 32'h0, 1'b1, 2'b00, 5'd5, 32'h0000_0004);
        run_txn("store", 1'b0, 1'b1, 3, 0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1'b0, 2'b00, 5'd0, 32'h0000_0008);
        run_txn("load",  1'b1, 1'b0, 0, 2, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 1'b1, 2'b01, 5'd7, 32'h0000_000C);
        run_txn("misal", 1'b1, 1'b0, 0, 0, 32'h0000_0041, 32'h0, 32'h0, 1'b1, 2'b01, 5'd8, 32'h0000_0010);
        run_txn("both",  1'b1, 1'b1, 1, 0, 32'h0000_0200, 32'h1357_9BDF, 32'h0, 1'b0, 2'b00, 5'd0, 32'h0000_0014);

        // Reset asserted while a load waits for read data.
        EX_MEM_RegWrite     = 1'b1;
        EX_MEM_MemtoReg     = 2'b01;
        EX_MEM_MemRead      = 1'b1;
        EX_MEM_MemWrite     = 1'b0;
        EX_MEM_ALUout       = 32'h0000_0080;
        EX_MEM_PCplus4      = 32'h0000_0018;
        EX_MEM_RegWriteAddr = 5'd9;
        bus.dmem_gnt        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.dmem_gnt = 1'b0;
        #1;
        check("wrd_req",   32'(bus.dmem_req), 32'h0);
        check("wrd_stall", 32'(mem_stall),    32'h1);
        reset = 1'b0;
        #1;
        check("mrst_req",   32'(bus.dmem_req), 32'h0);
        check("mrst_stall", 32'(mem_stall),    32'h0);
        check_mem_wb_zero("mrst");
        @(negedge clk);
        reset = 1'b1;
        // Back in IDLE, the held load must be issued again.
        run_txn("reissue", 1'b1, 1'b0, 0, 1, 32'h0000_0080, 32'h0, 32'h0BAD_F00D, 1'b1, 2'b01, 5'd9, 32'h0000_0018);

`ifdef MEM_TIMEOUT_EN
        // Store never granted: aborted in the 4th outstanding cycle.
        EX_MEM_RegWrite = 1'b0;
        EX_MEM_MemRead  = 1'b0;
        EX_MEM_MemWrite = 1'b1;
        EX_MEM_ALUout   = 32'h0000_0300;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("to_req",   32'(bus.dmem_req), 32'(c < 3));
            check("to_stall", 32'(mem_stall),    32'(c < 3));
            @(posedge clk);
            #1;
            check("to_err",    32'(mem_err),         32'(c == 3));
            check("to_bubble", 32'(MEM_WB_RegWrite), 32'h0);
            @(negedge clk);
        end
        run_txn("post_to", 1'b0, 1'b0, 0, 0, 32'h0000_5555, 32'h0, 32'h0, 1'b1, 2'b00, 5'd3, 32'h0000_001C);
`endif

        for (int i = 0; i < 200; i++) begin
            kind = int'($urandom_range(0, 4));
            rd   = (kind == 1) || (kind == 3) || (kind == 4);
            wr   = (kind == 2) || (kind == 3);
            rw   = 1'($urandom_range(0, 1));
            alu  = $urandom;
            if (kind == 4)      alu[1:0] = 2'($urandom_range(1, 3));
            else if (kind != 0) alu[1:0] = 2'b00;
            run_txn("rnd", rd, wr, int'($urandom_range(0, 2)), int'($urandom_range(1, 2)),
                    alu, $urandom, $urandom, rw, 2'($urandom_range(0, 3)),
                    5'($urandom_range(0, 31)), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
